// File: rtl/tlb_rd_data_route_pkg.sv
// Shared types for the TLB read-data routing stage: FSM encoding and destination width.
package lynxTypes;

  localparam int RD_DEST_BITS = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } route_state_t;

endpackage

// File: rtl/tlb_rd_data_route_buf.sv
// rd_route_buf: 2-entry per-destination output FIFO; full depends on registered count only.
module rd_route_buf #(
  parameter int DW = 64,
  parameter int KW = DW / 8
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic [KW-1:0] keep_i,
  input  logic          last_i,
  output logic          full_o,
  output logic [DW-1:0] m_tdata_o,
  output logic [KW-1:0] m_tkeep_o,
  output logic          m_tlast_o,
  output logic          m_tvalid_o,
  input  logic          m_tready_i
);

  logic [DW-1:0] data_q [2];
  logic [KW-1:0] keep_q [2];
  logic [1:0]    last_q;
  logic          wr_q, rd_q;
  logic [1:0]    cnt_q, cnt_d;
  logic          pop;

  assign m_tvalid_o = (cnt_q != 2'd0);
  assign full_o     = (cnt_q == 2'd2);
  assign pop        = m_tvalid_o & m_tready_i;

  assign m_tdata_o  = data_q[rd_q];
  assign m_tkeep_o  = keep_q[rd_q];
  // last is qualified so an empty slot never shows a stale end-of-burst marker
  assign m_tlast_o  = m_tvalid_o & last_q[rd_q];

  always_comb begin
    cnt_d = cnt_q;
    case ({push_i, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        keep_q[i] <= '0;
      end
      last_q <= '0;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (push_i) begin
        data_q[wr_q] <= data_i;
        keep_q[wr_q] <= keep_i;
        last_q[wr_q] <= last_i;
        wr_q         <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tlb_rd_data_route.sv
// Steers host read-data bursts to N_DEST buffered streams using the credit block's rd_dest.
// Optional RD_ROUTE_STATS_EN adds per-destination accepted-beat counters on stat_beats.
module tlb_rd_data_route
  import lynxTypes::*;
#(
  parameter int N_DEST         = 4,
  parameter int CRED_DATA_BITS = 64,
  parameter int AXI_DATA_BITS  = CRED_DATA_BITS
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [CRED_DATA_BITS-1:0]      s_tdata,
  input  logic [CRED_DATA_BITS/8-1:0]    s_tkeep,
  input  logic                           s_tlast,
  input  logic                           s_tvalid,
  output logic                           s_tready,
  input  logic [RD_DEST_BITS-1:0]        rd_dest,
  output logic                           rxfer,
  output logic [N_DEST*CRED_DATA_BITS-1:0]   m_tdata,
  output logic [N_DEST*CRED_DATA_BITS/8-1:0] m_tkeep,
  output logic [N_DEST-1:0]              m_tlast,
  output logic [N_DEST-1:0]              m_tvalid,
  input  logic [N_DEST-1:0]              m_tready,
  output logic                           err_dest,
  output logic                           dbg_state_o
`ifdef RD_ROUTE_STATS_EN
  ,
  output logic [N_DEST*16-1:0]           stat_beats
`endif
);

  localparam int KW = AXI_DATA_BITS / 8;
  localparam logic [RD_DEST_BITS:0] N_DEST_L = (RD_DEST_BITS + 1)'(N_DEST);

  route_state_t              state_q, state_d;
  logic [RD_DEST_BITS-1:0]   dest_q, dest_d;
  logic                      err_q, err_d;
  logic [RD_DEST_BITS-1:0]   target;
  logic                      tgt_ok;
  logic                      tgt_full;
  logic                      acc;
  logic [N_DEST-1:0]         full_v;
  logic [N_DEST-1:0]         push_v;

  // Handshake: a beat transfers on any cycle where s_tvalid && s_tready; s_tready
  // never depends on s_tvalid or m_tready, and invalid targets always drain.
  assign target   = (state_q == ST_BURST) ? dest_q : rd_dest;
  assign tgt_ok   = ({1'b0, target} < N_DEST_L);
  assign s_tready = tgt_ok ? ~tgt_full : 1'b1;
  assign acc      = s_tvalid & s_tready;
  assign rxfer    = acc;
  assign err_dest = err_q;
  assign dbg_state_o = state_q;

  always_comb begin
    tgt_full = 1'b0;
    push_v   = '0;
    for (int i = 0; i < N_DEST; i++) begin
      if (target == RD_DEST_BITS'(i)) begin
        tgt_full  = full_v[i];
        push_v[i] = acc;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    err_d   = err_q | (acc & ~tgt_ok);
    case (state_q)
      ST_IDLE: begin
        if (acc && !s_tlast) begin
          dest_d  = rd_dest;
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        if (acc && s_tlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      dest_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      err_q   <= err_d;
    end
  end

  for (genvar g = 0; g < N_DEST; g++) begin : g_dest
    rd_route_buf #(
      .DW(AXI_DATA_BITS),
      .KW(KW)
    ) u_buf (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .push_i     (push_v[g]),
      .data_i     (s_tdata),
      .keep_i     (s_tkeep),
      .last_i     (s_tlast),
      .full_o     (full_v[g]),
      .m_tdata_o  (m_tdata[g*AXI_DATA_BITS +: AXI_DATA_BITS]),
      .m_tkeep_o  (m_tkeep[g*KW +: KW]),
      .m_tlast_o  (m_tlast[g]),
      .m_tvalid_o (m_tvalid[g]),
      .m_tready_i (m_tready[g])
    );

`ifdef RD_ROUTE_STATS_EN
    logic [15:0] stat_q;
    always_ff @(posedge aclk) begin
      if (!aresetn)       stat_q <= '0;
      else if (push_v[g]) stat_q <= stat_q + 16'd1;
    end
    assign stat_beats[g*16 +: 16] = stat_q;
`endif
  end

endmodule

// File: tb/tb_tlb_rd_data_route.sv
// Bench for tlb_rd_data_route: directed scenarios plus randomized bursts against a queue model.
module tb_tlb_rd_data_route;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int KW = DW / 8;
  localparam int EW = 1 + KW + DW;

  logic              aclk;
  logic              aresetn;
  logic [DW-1:0]     s_tdata;
  logic [KW-1:0]     s_tkeep;
  logic              s_tlast;
  logic              s_tvalid;
  logic              s_tready;
  logic [3:0]        rd_dest;
  logic              rxfer;
  logic [N*DW-1:0]   m_tdata;
  logic [N*KW-1:0]   m_tkeep;
  logic [N-1:0]      m_tlast;
  logic [N-1:0]      m_tvalid;
  logic [N-1:0]      m_tready;
  logic              err_dest;
  logic              dbg_state;
`ifdef RD_ROUTE_STATS_EN
  logic [N*16-1:0]   stat_beats;
`endif

  tlb_rd_data_route #(.N_DEST(N), .CRED_DATA_BITS(DW)) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .s_tdata     (s_tdata),
    .s_tkeep     (s_tkeep),
    .s_tlast     (s_tlast),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .rd_dest     (rd_dest),
    .rxfer       (rxfer),
    .m_tdata     (m_tdata),
    .m_tkeep     (m_tkeep),
    .m_tlast     (m_tlast),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .err_dest    (err_dest),
    .dbg_state_o (dbg_state)
`ifdef RD_ROUTE_STATS_EN
    ,
    .stat_beats  (stat_beats)
`endif
  );

  // clock / reset
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_errors = 0;
  int rxfer_cnt = 0;
  int pop_cnt [N];
  bit rand_rdy_en = 0;

  // reference model: per-destination FIFO of {last, keep, data}, burst lock, sticky error
  logic [EW-1:0] exp_q [N][$];
  bit            mdl_burst;
  int            mdl_dest;
  bit            mdl_err;

  initial for (int d = 0; d < N; d++) pop_cnt[d] = 0;

  always @(negedge aclk) begin
    int  tgt;
    bit  ok, rdy;
    logic [EW-1:0] act, expv;
    if (!aresetn) begin
      for (int d = 0; d < N; d++) exp_q[d].delete();
      mdl_burst = 0;
      mdl_dest  = 0;
      mdl_err   = 0;
    end else begin
      tgt = mdl_burst ? mdl_dest : int'(rd_dest);
      ok  = (tgt < N);
      rdy = 1'b1;
      if (ok) rdy = (exp_q[tgt].size() < 2);
      n_checks++;
      if (s_tready !== rdy) begin
        n_errors++;
        $display("FAIL sb_s_tready: got %b want %b (tgt %0d)", s_tready, rdy, tgt);
      end
      n_checks++;
      if (rxfer !== (s_tvalid & rdy)) begin
        n_errors++;
        $display("FAIL sb_rxfer: got %b want %b", rxfer, s_tvalid & rdy);
      end
      n_checks++;
      if (err_dest !== mdl_err) begin
        n_errors++;
        $display("FAIL sb_err_dest: got %b want %b", err_dest, mdl_err);
      end
      n_checks++;
      if (dbg_state !== mdl_burst) begin
        n_errors++;
        $display("FAIL sb_state: got %b want %b", dbg_state, mdl_burst);
      end
      if (rxfer === 1'b1) rxfer_cnt++;
      for (int d = 0; d < N; d++) begin
        n_checks++;
        if (m_tvalid[d] !== (exp_q[d].size() != 0)) begin
          n_errors++;
          $display("FAIL sb_m_tvalid[%0d]: got %b want %b", d, m_tvalid[d], exp_q[d].size() != 0);
        end
        if (exp_q[d].size() != 0) begin
          act  = {m_tlast[d], m_tkeep[d*KW +: KW], m_tdata[d*DW +: DW]};
          expv = exp_q[d][0];
          n_checks++;
          if (act !== expv) begin
            n_errors++;
            $display("FAIL sb_beat[%0d]: got %h want %h", d, act, expv);
          end
          if (m_tready[d]) begin
            void'(exp_q[d].pop_front());
            pop_cnt[d]++;
          end
        end
      end
      if (s_tvalid && rdy) begin
        if (ok) exp_q[tgt].push_back({s_tlast, s_tkeep, s_tdata});
        else    mdl_err = 1;
        if (!mdl_burst && !s_tlast) begin
          mdl_burst = 1;
          mdl_dest  = int'(rd_dest);
        end else if (mdl_burst && s_tlast) begin
          mdl_burst = 0;
        end
      end
    end
  end

  // driver tasks: called at posedge+1, return at posedge+1 after the beat transfers
  task automatic drive_beat(input logic [3:0] dest, input logic last);
    int  waitc;
    bit  acc;
    s_tvalid = 1'b1;
    s_tdata  = DW'($urandom);
    s_tkeep  = KW'($urandom);
    s_tlast  = last;
    rd_dest  = dest;
    waitc    = 0;
    forever begin
      @(negedge aclk);
      acc = s_tready;
      @(posedge aclk);
      #1;
      if (acc) break;
      waitc++;
      if (waitc > 200) begin
        n_checks++;
        n_errors++;
        $display("FAIL beat_timeout: got no accept in %0d cycles, want accept", waitc);
        break;
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drive_burst(input int len, input logic [3:0] dest, input bit scramble);
    for (int b = 0; b < len; b++)
      drive_beat((scramble && b > 0) ? 4'($urandom) : dest, b == len - 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic do_reset(input int n);
    aresetn = 1'b0;
    idle(n);
    aresetn = 1'b1;
  endtask

  task automatic test_reset;
    s_tvalid = 0; s_tlast = 0; s_tdata = '0; s_tkeep = '0; rd_dest = '0;
    m_tready = '1;
    do_reset(3);
    n_checks++;
    if (s_tready !== 1'b1) begin n_errors++; $display("FAIL rst_s_tready: got %b want 1", s_tready); end
    n_checks++;
    if (m_tvalid !== '0) begin n_errors++; $display("FAIL rst_m_tvalid: got %b want 0", m_tvalid); end
    n_checks++;
    if (m_tlast !== '0) begin n_errors++; $display("FAIL rst_m_tlast: got %b want 0", m_tlast); end
    n_checks++;
    if (err_dest !== 1'b0) begin n_errors++; $display("FAIL rst_err_dest: got %b want 0", err_dest); end
    n_checks++;
    if (rxfer !== 1'b0) begin n_errors++; $display("FAIL rst_rxfer: got %b want 0", rxfer); end
    n_checks++;
    if (dbg_state !== 1'b0) begin n_errors++; $display("FAIL rst_state: got %b want 0", dbg_state); end
  endtask

  task automatic test_single_dest;
    int r0;
    m_tready = '1;
    r0 = rxfer_cnt;
    drive_beat(4'd2, 1'b0);
    n_checks++;
    if (m_tvalid !== 4'b0100) begin n_errors++; $display("FAIL single_latency: got %b want 0100", m_tvalid); end
    drive_beat(4'd2, 1'b0);
    drive_beat(4'd2, 1'b0);
    drive_beat(4'd2, 1'b1);
    n_checks++;
    if (m_tlast[2] !== 1'b1 || m_tvalid[2] !== 1'b1) begin
      n_errors++; $display("FAIL single_last: got v%b l%b want v1 l1", m_tvalid[2], m_tlast[2]);
    end
    idle(1);
    n_checks++;
    if (rxfer_cnt - r0 != 4) begin n_errors++; $display("FAIL single_rxfer: got %0d want 4", rxfer_cnt - r0); end
  endtask

  task automatic test_back_to_back;
    int p0, p1;
    time t0;
    m_tready = '1;
    p0 = pop_cnt[0];
    p1 = pop_cnt[1];
    t0 = $time;
    drive_burst(3, 4'd1, 1'b0);
    drive_burst(2, 4'd0, 1'b0);
    n_checks++;
    if (($time - t0) != 50) begin n_errors++; $display("FAIL b2b_bubble: got %0t want 50", $time - t0); end
    idle(3);
    n_checks++;
    if (pop_cnt[1] - p1 != 3 || pop_cnt[0] - p0 != 2) begin
      n_errors++; $display("FAIL b2b_split: got d1=%0d d0=%0d want 3 2", pop_cnt[1] - p1, pop_cnt[0] - p0);
    end
  endtask

  task automatic test_stall;
    int r0, p0, waitc;
    m_tready = 4'b1110;
    r0 = rxfer_cnt;
    p0 = pop_cnt[0];
    fork
      drive_burst(5, 4'd0, 1'b0);
      begin
        idle(6);
        n_checks++;
        if (rxfer_cnt - r0 != 2) begin n_errors++; $display("FAIL stall_accept: got %0d want 2", rxfer_cnt - r0); end
        n_checks++;
        if (s_tready !== 1'b0) begin n_errors++; $display("FAIL stall_ready: got %b want 0", s_tready); end
        m_tready[0] = 1'b1;
      end
    join
    waitc = 0;
    while (pop_cnt[0] - p0 < 5 && waitc < 20) begin idle(1); waitc++; end
    n_checks++;
    if (pop_cnt[0] - p0 != 5) begin n_errors++; $display("FAIL stall_drain: got %0d want 5", pop_cnt[0] - p0); end
  endtask

  task automatic test_invalid_dest;
    int r0;
    m_tready = '1;
    r0 = rxfer_cnt;
    drive_burst(3, 4'd7, 1'b0);
    idle(1);
    n_checks++;
    if (rxfer_cnt - r0 != 3) begin n_errors++; $display("FAIL inv_rxfer: got %0d want 3", rxfer_cnt - r0); end
    n_checks++;
    if (m_tvalid !== '0) begin n_errors++; $display("FAIL inv_m_tvalid: got %b want 0", m_tvalid); end
    n_checks++;
    if (err_dest !== 1'b1) begin n_errors++; $display("FAIL inv_err: got %b want 1", err_dest); end
    drive_burst(2, 4'd1, 1'b0);
    idle(2);
    n_checks++;
    if (err_dest !== 1'b1) begin n_errors++; $display("FAIL inv_err_sticky: got %b want 1", err_dest); end
  endtask

  task automatic test_mid_change;
    int p1, p3;
    m_tready = '1;
    p1 = pop_cnt[1];
    p3 = pop_cnt[3];
    drive_beat(4'd1, 1'b0);
    drive_beat(4'd3, 1'b0);
    drive_beat(4'd9, 1'b0);
    drive_beat(4'd3, 1'b1);
    idle(3);
    n_checks++;
    if (pop_cnt[1] - p1 != 4 || pop_cnt[3] - p3 != 0) begin
      n_errors++; $display("FAIL mid_change: got d1=%0d d3=%0d want 4 0", pop_cnt[1] - p1, pop_cnt[3] - p3);
    end
  endtask

  task automatic test_reset_mid_burst;
    int p3;
    m_tready = '0;
    drive_beat(4'd2, 1'b0);
    drive_beat(4'd2, 1'b0);
    n_checks++;
    if (m_tvalid[2] !== 1'b1 || dbg_state !== 1'b1) begin
      n_errors++; $display("FAIL rstmid_pre: got v%b s%b want v1 s1", m_tvalid[2], dbg_state);
    end
    do_reset(1);
    n_checks++;
    if (m_tvalid !== '0) begin n_errors++; $display("FAIL rstmid_flush: got %b want 0", m_tvalid); end
    n_checks++;
    if (dbg_state !== 1'b0) begin n_errors++; $display("FAIL rstmid_state: got %b want 0", dbg_state); end
    m_tready = '1;
    p3 = pop_cnt[3];
    drive_burst(1, 4'd3, 1'b0);
    n_checks++;
    if (m_tvalid !== 4'b1000 || m_tlast[3] !== 1'b1) begin
      n_errors++; $display("FAIL rstmid_single: got v%b l%b want v1000 l1", m_tvalid, m_tlast[3]);
    end
    idle(2);
    n_checks++;
    if (pop_cnt[3] - p3 != 1) begin n_errors++; $display("FAIL rstmid_deliver: got %0d want 1", pop_cnt[3] - p3); end
  endtask

  task automatic test_random;
    rand_rdy_en = 1;
    fork
      while (rand_rdy_en) begin
        @(posedge aclk);
        #1;
        if (rand_rdy_en) m_tready = N'($urandom);
      end
    join_none
    for (int k = 0; k < 60; k++) begin
      drive_burst($urandom_range(1, 4), 4'($urandom_range(0, 5)), $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    rand_rdy_en = 0;
    idle(1);
    m_tready = '1;
    idle(4);
    n_checks++;
    if (m_tvalid !== '0) begin n_errors++; $display("FAIL rand_drain: got %b want 0", m_tvalid); end
  endtask

  initial begin
    aresetn = 1'b0;
    test_reset;
    test_single_dest;
    test_back_to_back;
    test_stall;
    test_invalid_dest;
    test_mid_change;
    test_reset_mid_burst;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1);
  end

endmodule
